line_job_scheduler: RTL and testbench

- Front-end controller for the line_drawer datapath: accepts segment jobs (endpoints plus colour) over a valid/ready port, buffers them in a small FIFO and runs them on a single line_drawer one at a time.
- Forwards the drawer's per-cycle coordinates as framebuffer pixel writes.
- Sits between game-object renderers (pipes, bird outline, erase passes) and the VGA framebuffer write port.
- Provides a watchdog and a zero-length-segment bypass.

---
 rtl/line_job_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_line_job_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_job_scheduler.sv
// Segment-job front end for a single line_drawer: queues jobs in a small FIFO, sequences
// the drawer one job at a time and turns its coordinate stream into framebuffer writes.
package line_job_scheduler_pkg;
    localparam int unsigned CW = 11;

    typedef struct packed {
        logic [CW-1:0] x0;
        logic [CW-1:0] y0;
        logic [CW-1:0] x1;
        logic [CW-1:0] y1;
        logic          color;
    } job_t;
endpackage

module line_job_scheduler
    import line_job_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 2047
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [CW-1:0] req_x0,
    input  logic [CW-1:0] req_y0,
    input  logic [CW-1:0] req_x1,
    input  logic [CW-1:0] req_y1,
    input  logic          req_color,
    output logic          ld_reset,
    output logic [CW-1:0] ld_x0,
    output logic [CW-1:0] ld_y0,
    output logic [CW-1:0] ld_x1,
    output logic [CW-1:0] ld_y1,
    input  logic [CW-1:0] ld_x,
    input  logic [CW-1:0] ld_y,
    input  logic          ld_move,
    output logic          pix_we,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          pix_color,
    output logic          busy,
    output logic          err,
    output logic [15:0]   jobs_done
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NW = AW + 1;
    localparam int unsigned TW = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAW  = 3'd2,
        POINT = 3'd3,
        ABORT = 3'd4
    } state_t;

    state_t        state;
    job_t          fifo_mem [DEPTH];
    job_t          in_job;
    job_t          head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [NW-1:0] count;
    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_inc;
    logic          job_color;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    logic          head_is_point;

    assign in_job = '{x0: req_x0, y0: req_y0, x1: req_x1, y1: req_y1, color: req_color};
    assign head   = fifo_mem[rd_ptr];

    assign full      = (count == NW'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !reset && !full;
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && !empty;

    assign head_is_point = (head.x0 == head.x1) && (head.y0 == head.y1);
    assign cnt_inc       = (cnt == '1) ? cnt : cnt + TW'(1);

    // A registered write still in flight keeps the block busy.
    assign busy = !empty || (state != IDLE) || pix_we;

    // Job storage; pushes are already blocked during reset through req_ready.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_job;
        end
    end

    // Control FSM, FIFO pointers and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            cnt       <= '0;
            job_color <= 1'b0;
            ld_reset  <= 1'b1;
            ld_x0     <= '0;
            ld_y0     <= '0;
            ld_x1     <= '0;
            ld_y1     <= '0;
            pix_we    <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= 1'b0;
            err       <= 1'b0;
            jobs_done <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count + NW'(push) - NW'(pop);
            ld_reset <= 1'b0;
            pix_we   <= 1'b0;

            case (state)
                IDLE: begin
                    if (pop) begin
                        ld_x0     <= head.x0;
                        ld_y0     <= head.y0;
                        ld_x1     <= head.x1;
                        ld_y1     <= head.y1;
                        job_color <= head.color;
                        if (head_is_point) begin
                            state <= POINT;
                        end else begin
                            state    <= LOAD;
                            ld_reset <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= DRAW;
                end
                DRAW: begin
                    // Cycle 0 carries no coordinate; the move cycle follows the last one.
                    cnt       <= cnt_inc;
                    pix_we    <= (cnt != '0) && !ld_move;
                    pix_x     <= ld_x;
                    pix_y     <= ld_y;
                    pix_color <= job_color;
                    if (ld_move) begin
                        jobs_done <= jobs_done + 16'd1;
                        state     <= IDLE;
                    end else if (cnt_inc == TW'(TIMEOUT)) begin
                        err      <= 1'b1;
                        ld_reset <= 1'b1;
                        state    <= ABORT;
                    end
                end
                POINT: begin
                    pix_we    <= 1'b1;
                    pix_x     <= ld_x0;
                    pix_y     <= ld_y0;
                    pix_color <= job_color;
                    jobs_done <= jobs_done + 16'd1;
                    state     <= IDLE;
                end
                ABORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_line_job_scheduler.sv
// Directed bench for line_job_scheduler with a behavioural line_drawer attached.
module tb_line_job_scheduler;
    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        c;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [10:0] req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
    logic        req_color = 1'b0;
    logic        ld_reset;
    logic [10:0] ld_x0, ld_y0, ld_x1, ld_y1;
    logic [10:0] ld_x, ld_y;
    logic        ld_move;
    logic        pix_we;
    logic [10:0] pix_x, pix_y;
    logic        pix_color;
    logic        busy;
    logic        err;
    logic [15:0] jobs_done;

    int checks = 0;
    int failures = 0;
    int exp_done = 0;
    int cyc = 0;
    pix_t pix_q[$];
    pix_t exp_q[$];
    int   ldr_q[$];

    line_job_scheduler #(.DEPTH(4), .TIMEOUT(20)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
        .req_color(req_color),
        .ld_reset(ld_reset), .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1), .ld_y1(ld_y1),
        .ld_x(ld_x), .ld_y(ld_y), .ld_move(ld_move),
        .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .busy(busy), .err(err), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drawer model: point j (0-based) appears at draw cycle j+1, move one cycle after the last.
    logic [10:0] d_x0 = '0, d_y0 = '0, d_x1 = '0, d_y1 = '0;
    int   d_k = 0;
    logic d_active = 1'b0;
    logic d_stub = 1'b0;
    logic stub_mode = 1'b0;

    function automatic int adist(input logic [10:0] a, input logic [10:0] b);
        return (b >= a) ? int'(b - a) : int'(a - b);
    endfunction

    function automatic logic [10:0] step(input logic [10:0] a, input logic [10:0] b, input int j);
        int m;
        m = (j < adist(a, b)) ? j : adist(a, b);
        return (b >= a) ? a + 11'(m) : a - 11'(m);
    endfunction

    always @(posedge clk) begin
        if (ld_reset) begin
            d_x0 <= ld_x0; d_y0 <= ld_y0; d_x1 <= ld_x1; d_y1 <= ld_y1;
            d_k <= 0;
            d_active <= (ld_x0 != ld_x1) || (ld_y0 != ld_y1);
            d_stub <= stub_mode;
        end else begin
            d_k <= d_k + 1;
            if (ld_move) d_active <= 1'b0;
        end
    end

    always_comb begin
        int n;
        n = (adist(d_x0, d_x1) > adist(d_y0, d_y1)) ? adist(d_x0, d_x1) : adist(d_y0, d_y1);
        ld_move = d_active && !d_stub && (d_k == n + 1);
        ld_x = (d_k >= 1) ? step(d_x0, d_x1, d_k - 1) : d_x0;
        ld_y = (d_k >= 1) ? step(d_y0, d_y1, d_k - 1) : d_y0;
    end

    always @(negedge clk) begin
        if (pix_we === 1'b1) pix_q.push_back('{x: pix_x, y: pix_y, c: pix_color});
        if (reset === 1'b0 && ld_reset === 1'b1) ldr_q.push_back(cyc);
    end

    task automatic exp_add(input int x, input int y, input logic c);
        exp_q.push_back('{x: 11'(x), y: 11'(y), c: c});
    endtask

    task automatic push_job(input int x0, input int y0, input int x1, input int y1, input logic c);
        int t = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_x0 = 11'(x0); req_y0 = 11'(y0); req_x1 = 11'(x1); req_y1 = 11'(y1);
        req_color = c;
        while (req_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++; failures++;
            $display("FAIL push_wait req_ready stuck at %b, required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            checks++; failures++;
            $display("FAIL %s_idle busy=%b after %0d cycles, required 0", name, busy, t);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (ld_reset !== 1'b1) begin failures++; $display("FAIL rst_ld_reset actual=%b required=1", ld_reset); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready actual=%b required=0", req_ready); end
        checks++; if (pix_we !== 1'b0) begin failures++; $display("FAIL rst_pix_we actual=%b required=0", pix_we); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy actual=%b required=0", busy); end
        checks++; if (err !== 1'b0 || jobs_done !== 16'd0) begin failures++; $display("FAIL rst_err_done actual=%b/%0d required=0/0", err, jobs_done); end
        checks++; if ({ld_x0, ld_y0, ld_x1, ld_y1, pix_x, pix_y} !== 66'd0) begin failures++; $display("FAIL rst_coords actual=%h required=0", {ld_x0, ld_y0, ld_x1, ld_y1, pix_x, pix_y}); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || ld_reset !== 1'b0) begin failures++; $display("FAIL rst_release ready/ld_reset actual=%b/%b required=1/0", req_ready, ld_reset); end
    endtask

    task automatic test_horizontal;
        pix_q.delete(); exp_q.delete(); ldr_q.delete();
        for (int i = 0; i < 5; i++) exp_add(i, 0, 1'b1);
        push_job(0, 0, 5, 0, 1'b1);
        wait_idle("horiz");
        exp_done += 1;
        checks++; if (pix_q.size() != exp_q.size()) begin failures++; $display("FAIL horiz_count actual=%0d required=%0d", pix_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pix_q.size(); i++) begin
            checks++;
            if (pix_q[i] !== exp_q[i]) begin failures++; $display("FAIL horiz_pix[%0d] actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)", i, pix_q[i].x, pix_q[i].y, pix_q[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c); end
        end
        checks++; if (jobs_done !== 16'(exp_done)) begin failures++; $display("FAIL horiz_done actual=%0d required=%0d", jobs_done, exp_done); end
        checks++; if (ldr_q.size() != 1) begin failures++; $display("FAIL horiz_ld_reset_pulses actual=%0d required=1", ldr_q.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL horiz_busy actual=%b required=0", busy); end
    endtask

    task automatic test_back_to_back;
        pix_q.delete(); exp_q.delete(); ldr_q.delete();
        for (int i = 0; i < 12; i++) exp_add(i, 10, 1'b1);
        for (int i = 0; i < 3; i++) exp_add(20, 5 + i, 1'b0);
        for (int i = 0; i < 3; i++) exp_add(30 + i, 30 + i, 1'b1);
        for (int i = 0; i < 3; i++) exp_add(50 - i, 40, 1'b1);
        exp_add(1, 2, 1'b1);
        push_job(0, 10, 12, 10, 1'b1);
        push_job(20, 5, 20, 8, 1'b0);
        push_job(30, 30, 33, 33, 1'b1);
        push_job(50, 40, 47, 40, 1'b1);
        push_job(1, 2, 1, 2, 1'b1);
        // First job is still drawing, so the four queued jobs fill the FIFO.
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready actual=%b required=0", req_ready); end
        wait_idle("b2b");
        exp_done += 5;
        checks++; if (pix_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count actual=%0d required=%0d", pix_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pix_q.size(); i++) begin
            checks++;
            if (pix_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_pix[%0d] actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)", i, pix_q[i].x, pix_q[i].y, pix_q[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c); end
        end
        checks++; if (jobs_done !== 16'(exp_done)) begin failures++; $display("FAIL b2b_done actual=%0d required=%0d", jobs_done, exp_done); end
        checks++; if (ldr_q.size() != 4) begin failures++; $display("FAIL b2b_ld_reset_pulses actual=%0d required=4", ldr_q.size()); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after actual=%b required=1", req_ready); end
    endtask

    task automatic test_zero_length;
        pix_q.delete(); ldr_q.delete();
        push_job(7, 9, 7, 9, 1'b0);
        wait_idle("zero");
        exp_done += 1;
        checks++; if (pix_q.size() != 1) begin failures++; $display("FAIL zero_count actual=%0d required=1", pix_q.size()); end
        else begin
            checks++;
            if (pix_q[0] !== pix_t'{x: 11'd7, y: 11'd9, c: 1'b0}) begin failures++; $display("FAIL zero_pix actual=(%0d,%0d,%0d) required=(7,9,0)", pix_q[0].x, pix_q[0].y, pix_q[0].c); end
        end
        checks++; if (ldr_q.size() != 0) begin failures++; $display("FAIL zero_ld_reset_pulses actual=%0d required=0", ldr_q.size()); end
        checks++; if (jobs_done !== 16'(exp_done)) begin failures++; $display("FAIL zero_done actual=%0d required=%0d", jobs_done, exp_done); end
    endtask

    task automatic test_timeout;
        int t = 0;
        pix_q.delete(); exp_q.delete(); ldr_q.delete();
        for (int i = 0; i < 19; i++) exp_add(i, 0, 1'b1);
        exp_add(3, 3, 1'b1);
        exp_add(4, 3, 1'b1);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL tmo_err_before actual=%b required=0", err); end
        stub_mode = 1'b1;
        push_job(0, 0, 40, 0, 1'b1);
        push_job(3, 3, 5, 3, 1'b1);
        while (err !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_err actual=%b required=1", err); end
        stub_mode = 1'b0;
        checks++; if (ld_reset !== 1'b1) begin failures++; $display("FAIL tmo_abort_ld_reset actual=%b required=1", ld_reset); end
        @(negedge clk);
        checks++; if (ld_reset !== 1'b0) begin failures++; $display("FAIL tmo_abort_width actual=%b required=0", ld_reset); end
        wait_idle("tmo");
        exp_done += 1;
        checks++; if (ldr_q.size() != 3) begin failures++; $display("FAIL tmo_ld_reset_pulses actual=%0d required=3", ldr_q.size()); end
        else begin
            checks++; if (ldr_q[1] - ldr_q[0] != 21) begin failures++; $display("FAIL tmo_draw_cycles actual=%0d required=20", ldr_q[1] - ldr_q[0] - 1); end
            checks++; if (ldr_q[2] - ldr_q[1] != 2) begin failures++; $display("FAIL tmo_next_load_gap actual=%0d required=2", ldr_q[2] - ldr_q[1]); end
        end
        checks++; if (pix_q.size() != exp_q.size()) begin failures++; $display("FAIL tmo_count actual=%0d required=%0d", pix_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pix_q.size(); i++) begin
            checks++;
            if (pix_q[i] !== exp_q[i]) begin failures++; $display("FAIL tmo_pix[%0d] actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)", i, pix_q[i].x, pix_q[i].y, pix_q[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c); end
        end
        checks++; if (jobs_done !== 16'(exp_done)) begin failures++; $display("FAIL tmo_done actual=%0d required=%0d", jobs_done, exp_done); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_err_sticky actual=%b required=1", err); end
    endtask

    task automatic test_reset_mid;
        push_job(0, 0, 100, 300, 1'b1);
        push_job(1, 1, 4, 1, 1'b1);
        push_job(2, 2, 2, 6, 1'b0);
        repeat (4) @(negedge clk);
        checks++; if (pix_we !== 1'b1) begin failures++; $display("FAIL rmid_drawing actual=%b required=1", pix_we); end
        reset = 1'b1;
        @(negedge clk);
        pix_q.delete();
        checks++; if (pix_we !== 1'b0 || ld_reset !== 1'b1 || req_ready !== 1'b0) begin failures++; $display("FAIL rmid_in_reset we/ld_reset/ready actual=%b/%b/%b required=0/1/0", pix_we, ld_reset, req_ready); end
        checks++; if (busy !== 1'b0 || err !== 1'b0 || jobs_done !== 16'd0) begin failures++; $display("FAIL rmid_state busy/err/done actual=%b/%b/%0d required=0/0/0", busy, err, jobs_done); end
        checks++; if ({ld_x0, ld_y0, ld_x1, ld_y1, pix_x, pix_y, pix_color} !== 67'd0) begin failures++; $display("FAIL rmid_coords actual=%h required=0", {ld_x0, ld_y0, ld_x1, ld_y1, pix_x, pix_y, pix_color}); end
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        exp_done = 0;
        checks++; if (pix_q.size() != 0) begin failures++; $display("FAIL rmid_no_writes actual=%0d required=0", pix_q.size()); end
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rmid_fifo_empty busy/ready actual=%b/%b required=0/1", busy, req_ready); end
    endtask

    task automatic test_push_pop;
        int t = 0;
        pix_q.delete(); exp_q.delete();
        for (int i = 0; i < 8; i++) exp_add(i, 0, 1'b1);
        exp_add(5, 5, 1'b0);
        exp_add(5, 6, 1'b0);
        exp_add(9, 9, 1'b1);
        exp_add(2, 1, 1'b1);
        exp_add(3, 1, 1'b1);
        push_job(0, 0, 8, 0, 1'b1);
        push_job(5, 5, 5, 7, 1'b0);
        push_job(9, 9, 9, 9, 1'b1);
        while (ld_move !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++; if (ld_move !== 1'b1) begin failures++; $display("FAIL pp_move_seen actual=%b required=1", ld_move); end
        // Next cycle is IDLE with two jobs queued: offer a job as the head is popped.
        @(negedge clk);
        req_valid = 1'b1;
        req_x0 = 11'd2; req_y0 = 11'd1; req_x1 = 11'd4; req_y1 = 11'd1; req_color = 1'b1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL pp_ready actual=%b required=1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle("pp");
        exp_done += 4;
        checks++; if (pix_q.size() != exp_q.size()) begin failures++; $display("FAIL pp_count actual=%0d required=%0d", pix_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pix_q.size(); i++) begin
            checks++;
            if (pix_q[i] !== exp_q[i]) begin failures++; $display("FAIL pp_pix[%0d] actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)", i, pix_q[i].x, pix_q[i].y, pix_q[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c); end
        end
        checks++; if (jobs_done !== 16'(exp_done)) begin failures++; $display("FAIL pp_done actual=%0d required=%0d", jobs_done, exp_done); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_horizontal();
        test_back_to_back();
        test_zero_length();
        test_timeout();
        test_reset_mid();
        test_push_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
